// File: rtl/state_dump_streamer.sv
// state_dump_streamer
//   Post-run observability engine. On start it walks the register file
//   (x0..x(NUM_REGS-1)) and then data memory (word 0..MEM_WORDS-1). Each entry
//   goes out over a valid/ready stream through a 2-entry output FIFO.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start, abort      begin a dump (IDLE only); synchronous cancel
//   rf_addr/rf_data   register-file read port (combinational read)
//   mem_addr/mem_rd   data-memory read request; mem_data valid one cycle later
//   out_valid/ready   stream handshake; out_kind/out_addr/out_data = FIFO head
//   busy, done        dump in progress; one-cycle completion pulse
module state_dump_streamer #(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 512,
    parameter int MEM_AW    = 9,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [15:0]       out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);
    localparam int                EW       = 1 + 16 + DATA_W;
    localparam logic [4:0]        RF_LAST  = 5'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(MEM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RF    = 3'd1,
        S_MEM   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [4:0]        rf_idx_r;
    logic [MEM_AW-1:0] mem_idx_r, pend_idx_r;
    logic              pend_r;
    logic [1:0]        cnt_r;
    logic [EW-1:0]     slot0_r, slot1_r;

    logic              pop_s, push_s, room_s;
    logic              rf_issue_s, mem_issue_s, cross_s;
    logic [2:0]        occ_s;
    logic [EW-1:0]     push_entry_s;

    function automatic logic [EW-1:0] pack_entry(input logic kind,
                                                 input logic [15:0] addr,
                                                 input logic [DATA_W-1:0] data);
        return {kind, addr, data};
    endfunction

    // Read issue decisions and selection of the entry pushed into the FIFO
    always_comb begin
        pop_s       = out_valid && out_ready;
        // Occupancy seen by a new read once this cycle's pop has freed its slot
        occ_s       = {1'b0, cnt_r} + {2'b00, pend_r} - {2'b00, pop_s};
        room_s      = (occ_s < 3'd2);
        rf_issue_s  = 1'b0;
        cross_s     = 1'b0;
        mem_issue_s = 1'b0;
        if (!abort && (state_r == S_RF) && room_s) begin
            rf_issue_s = 1'b1;
            // Launch M[0] together with the last register when both fit, so the
            // one-cycle memory latency does not open a bubble at the crossing.
            cross_s    = (rf_idx_r == RF_LAST) && (occ_s == 3'd0);
        end else begin
            rf_issue_s = 1'b0;
        end
        if (!abort && (((state_r == S_MEM) && room_s) || cross_s)) begin
            mem_issue_s = 1'b1;
        end else begin
            mem_issue_s = 1'b0;
        end
        // A landing memory word and a register read never coincide
        push_s = !abort && (pend_r || rf_issue_s);
        if (pend_r) begin
            push_entry_s = pack_entry(1'b1, 16'({pend_idx_r, 2'b00}), mem_data);
        end else begin
            push_entry_s = pack_entry(1'b0, {11'b0, rf_idx_r}, rf_data);
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) state_s = S_RF;
                else                 state_s = S_IDLE;
            end
            S_RF: begin
                if (abort)                                 state_s = S_IDLE;
                else if (cross_s && (mem_idx_r == MEM_LAST)) state_s = S_DRAIN;
                else if (rf_issue_s && (rf_idx_r == RF_LAST)) state_s = S_MEM;
                else                                       state_s = S_RF;
            end
            S_MEM: begin
                if (abort)                                      state_s = S_IDLE;
                else if (mem_issue_s && (mem_idx_r == MEM_LAST)) state_s = S_DRAIN;
                else                                            state_s = S_MEM;
            end
            S_DRAIN: begin
                // Finish in the cycle the last entry is accepted
                if (abort) state_s = S_IDLE;
                else if (!pend_r && ((cnt_r == 2'd0) || ((cnt_r == 2'd1) && pop_s)))
                    state_s = S_DONE;
                else
                    state_s = S_DRAIN;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_IDLE;
        else      state_r <= state_s;
    end

    // Walk counters: cleared in IDLE, saturate at the final index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_idx_r  <= 5'd0;
            mem_idx_r <= '0;
        end else if (state_r == S_IDLE) begin
            rf_idx_r  <= 5'd0;
            mem_idx_r <= '0;
        end else begin
            if (rf_issue_s && (rf_idx_r != RF_LAST))
                rf_idx_r <= rf_idx_r + 5'd1;
            if (mem_issue_s && (mem_idx_r != MEM_LAST))
                mem_idx_r <= mem_idx_r + MEM_AW'(1);
        end
    end

    // In-flight memory read tracking (issue is already suppressed by abort)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r     <= 1'b0;
            pend_idx_r <= '0;
        end else begin
            pend_r <= mem_issue_s;
            if (mem_issue_s) pend_idx_r <= mem_idx_r;
        end
    end

    // Two-entry output FIFO; slot0 is the head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 2'd0;
            slot0_r <= '0;
            slot1_r <= '0;
        end else if (abort) begin
            cnt_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) slot0_r <= push_entry_s;
                    else               slot1_r <= push_entry_s;
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    cnt_r   <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        slot0_r <= push_entry_s;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_entry_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = (cnt_r != 2'd0);
    assign out_kind  = slot0_r[EW-1];
    assign out_addr  = slot0_r[EW-2 -: 16];
    assign out_data  = slot0_r[DATA_W-1:0];
    assign rf_addr   = rf_idx_r;
    assign mem_addr  = mem_idx_r;
    assign mem_rd    = mem_issue_s;
    assign busy      = (state_r == S_RF) || (state_r == S_MEM) || (state_r == S_DRAIN);
    assign done      = (state_r == S_DONE);

endmodule
